mem_data_buffer: RTL and testbench

Parametrised successor to the processor's single 16-bit memory data register. It buffers up to DEPTH memory words between the memory side and the datapath, using valid/ready handshakes on both sides. It adds per-byte input masking and an output extension mode for byte loads. It sits between the memory read port and the datapath register-file write-back.

---
 rtl/mdr_pkg.sv | 13 +
 rtl/mem_data_buffer_if.sv | 28 ++
 rtl/mdr_extend.sv | 22 ++
 rtl/mem_data_buffer.sv | 80 ++++++++
 tb/tb_mem_data_buffer.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/mdr_pkg.sv
// Shared constants and helpers for the memory data buffer.
package mdr_pkg;

  localparam logic [1:0] MODE_WORD  = 2'b00;
  localparam logic [1:0] MODE_ZEXT8 = 2'b01;
  localparam logic [1:0] MODE_SEXT8 = 2'b10;

  // One extra bit so the count can represent a completely full buffer.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/mem_data_buffer_if.sv
// Memory-side and datapath-side handshake bundle for mem_data_buffer.
interface mem_data_buffer_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
);
  localparam int LANES = WIDTH / 8;
  localparam int CNT_W = mdr_pkg::cnt_width(DEPTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [LANES-1:0] in_be;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       out_mode;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] count;

  modport master (
    output in_valid, in_data, in_be, out_ready, out_mode,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  in_valid, in_data, in_be, out_ready, out_mode,
    output in_ready, out_valid, out_data, count
  );
endinterface

// File: rtl/mdr_extend.sv
// Read-time shaping of the head word: full word, or low byte zero/sign extended.
module mdr_extend
  import mdr_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] head_i,
  input  logic [1:0]       mode_i,
  output logic [WIDTH-1:0] data_o
);

  always_comb begin
    data_o = head_i;
    case (mode_i)
      MODE_WORD:  data_o = head_i;
      MODE_ZEXT8: data_o = {{(WIDTH-8){1'b0}}, head_i[7:0]};
      MODE_SEXT8: data_o = {{(WIDTH-8){head_i[7]}}, head_i[7:0]};
      default:    data_o = head_i;
    endcase
  end

endmodule

// File: rtl/mem_data_buffer.sv
// Circular buffer of memory words between the memory read port and write-back,
// with per-byte write masking and byte-load extension on the read side.
module mem_data_buffer
  import mdr_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  mem_data_buffer_if.slave bus
);

  localparam int LANES = WIDTH / 8;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;
  logic [WIDTH-1:0] wr_word;
  logic [WIDTH-1:0] head_word;

  // Handshake flags come from registered count only, so in_ready never sees out_ready.
  assign bus.in_ready  = (count_q != FULL);
  assign bus.out_valid = (count_q != '0);
  assign bus.count     = count_q;

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  always_comb begin
    wr_word = '0;
    for (int l = 0; l < LANES; l++) begin
      if (bus.in_be[l]) wr_word[l*8 +: 8] = bus.in_data[l*8 +: 8];
    end
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && rst_n && !flush) mem_q[wr_ptr_q] <= wr_word;
  end

  // Stale array contents are hidden whenever the buffer is empty.
  assign head_word = (count_q == '0) ? '0 : mem_q[rd_ptr_q];

  mdr_extend #(.WIDTH(WIDTH)) u_extend (
    .head_i (head_word),
    .mode_i (bus.out_mode),
    .data_o (bus.out_data)
  );

endmodule

// File: tb/tb_mem_data_buffer.sv
// Directed and randomized checks of mem_data_buffer against a queue-based reference.
module tb_mem_data_buffer;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;
  logic flush;

  mem_data_buffer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  mem_data_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [WIDTH-1:0] model_q[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

  function automatic logic [WIDTH-1:0] mask_word(input logic [WIDTH-1:0] d, input logic [1:0] be);
    logic [WIDTH-1:0] r;
    r = 0;
    if (be[0]) r = r + (d % 256);
    if (be[1]) r = r + ((d / 256) % 256) * 256;
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] shape(input logic [WIDTH-1:0] w, input logic [1:0] mode);
    int lo;
    lo = w % 256;
    if (mode == 2'b01) return WIDTH'(lo);
    if (mode == 2'b10) return (lo >= 128) ? WIDTH'(65536 - 256 + lo) : WIDTH'(lo);
    return w;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_model(input string tag);
    logic [WIDTH-1:0] exp_data;
    exp_data = (model_q.size() == 0) ? '0 : shape(model_q[0], bus.out_mode);
    check({tag, "_count"},     32'(bus.count),     32'(model_q.size()));
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'(model_q.size() != 0));
    check({tag, "_in_ready"},  32'(bus.in_ready),  32'(model_q.size() != DEPTH));
    check({tag, "_out_data"},  32'(bus.out_data),  32'(exp_data));
  endtask

  task automatic cyc(input string tag);
    bit do_push, do_pop;
    logic [WIDTH-1:0] w;
    do_push = bus.in_valid && (model_q.size() < DEPTH);
    do_pop  = bus.out_ready && (model_q.size() > 0);
    w = mask_word(bus.in_data, bus.in_be);
    @(posedge clk);
    if (!rst_n || flush) model_q.delete();
    else begin
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back(w);
    end
    #1;
    check_model(tag);
  endtask

  task automatic push_word(input logic [WIDTH-1:0] d, input logic [1:0] be);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_be    = be;
    cyc("push");
    bus.in_valid = 1'b0;
  endtask

  task automatic pop_word();
    bus.out_ready = 1'b1;
    cyc("pop");
    bus.out_ready = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_be     = 2'b11;
    bus.out_ready = 1'b0;
    bus.out_mode  = 2'b00;

    // Reset held for two cycles
    cyc("rst");
    cyc("rst");
    rst_n = 1'b1;
    cyc("rst_rel");
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_data", 32'(bus.out_data), 32'h0000);

    // Fill and drain
    push_word(16'd54, 2'b11);
    push_word(16'd977, 2'b11);
    push_word(16'd0, 2'b11);
    push_word(16'd6516, 2'b11);
    check("fill_count", 32'(bus.count), 32'd4);
    check("fill_in_ready", 32'(bus.in_ready), 32'd0);
    check("drain0", 32'(bus.out_data), 32'd54);
    bus.out_ready = 1'b1;
    cyc("drain");
    check("drain1", 32'(bus.out_data), 32'd977);
    cyc("drain");
    check("drain2", 32'(bus.out_data), 32'd0);
    cyc("drain");
    check("drain3", 32'(bus.out_data), 32'd6516);
    cyc("drain");
    check("drain_empty", 32'(bus.count), 32'd0);
    bus.out_ready = 1'b0;

    // Move pointers to index 3, then straddle the wrap with a push/pop overlap
    push_word(16'd11, 2'b11);
    push_word(16'd22, 2'b11);
    push_word(16'd33, 2'b11);
    pop_word();
    pop_word();
    pop_word();
    push_word(16'd100, 2'b11);
    push_word(16'd200, 2'b11);
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'd515;
    bus.out_ready = 1'b1;
    cyc("simul");
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("simul_count", 32'(bus.count), 32'd2);
    check("simul_head", 32'(bus.out_data), 32'd200);
    pop_word();
    check("wrap_head", 32'(bus.out_data), 32'd515);
    pop_word();

    // Byte masking and extension
    push_word(16'h1B0C, 2'b01);
    check("mask_lo", 32'(bus.out_data), 32'h000C);
    pop_word();
    push_word(16'h00F3, 2'b11);
    bus.out_mode = 2'b10;
    #1;
    check("sext", 32'(bus.out_data), 32'hFFF3);
    bus.out_mode = 2'b01;
    #1;
    check("zext", 32'(bus.out_data), 32'h00F3);
    bus.out_mode = 2'b11;
    #1;
    check("mode11", 32'(bus.out_data), 32'h00F3);
    bus.out_mode = 2'b00;
    pop_word();

    // Full boundary: pop-only cycle, then the held word goes in
    push_word(16'd1, 2'b11);
    push_word(16'd2, 2'b11);
    push_word(16'd3, 2'b11);
    push_word(16'd4, 2'b11);
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'd333;
    bus.in_be     = 2'b11;
    bus.out_ready = 1'b1;
    cyc("full_pop");
    check("full_pop_count", 32'(bus.count), 32'd3);
    check("full_pop_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b0;
    cyc("full_push");
    bus.in_valid = 1'b0;
    check("full_push_count", 32'(bus.count), 32'd4);

    // Flush and reset priority
    pop_word();
    check("pre_flush_count", 32'(bus.count), 32'd3);
    flush        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'd1804;
    cyc("flush");
    check("flush_count", 32'(bus.count), 32'd0);
    flush = 1'b0;
    rst_n = 1'b0;
    cyc("rst_push");
    check("rst_push_count", 32'(bus.count), 32'd0);
    check("rst_push_valid", 32'(bus.out_valid), 32'd0);
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    cyc("idle");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_data   = 16'($urandom());
      bus.in_be     = 2'($urandom_range(0, 3));
      bus.out_ready = 1'($urandom_range(0, 2) == 0);
      bus.out_mode  = 2'($urandom_range(0, 3));
      flush         = ($urandom_range(0, 40) == 0);
      rst_n         = ($urandom_range(0, 80) != 0);
      cyc("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
